// File: rtl/serial_alu_pkg.sv
// Shared op codes and FSM state encoding for the bit-serial ALU.
package serial_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_alu_if.sv
// Operand/result handshake bundle for serial_alu.
// The ovf signal exists only when SERIAL_ALU_OVF_EN is defined.
interface serial_alu_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag;
`ifdef SERIAL_ALU_OVF_EN
  logic             ovf;

  modport master (
    output in_valid, op, a, b, cin, out_ready,
    input  in_ready, out_valid, result, flag, ovf
  );

  modport slave (
    input  in_valid, op, a, b, cin, out_ready,
    output in_ready, out_valid, result, flag, ovf
  );
`else
  modport master (
    output in_valid, op, a, b, cin, out_ready,
    input  in_ready, out_valid, result, flag
  );

  modport slave (
    input  in_valid, op, a, b, cin, out_ready,
    output in_ready, out_valid, result, flag
  );
`endif

endinterface

// File: rtl/serial_alu_cell.sv
// Combinational 1-bit add / subtract / parity cell used by serial_alu.
module serial_alu_cell
  import serial_alu_pkg::*;
(
  input  logic       a_bit,
  input  logic       b_bit,
  input  logic       c_in,
  input  logic       seed,
  input  logic [1:0] op,
  output logic       s,
  output logic       c_out
);

  // Parity emits a^b^seed per bit while c_in/c_out carry the running XOR.
  always_comb begin
    s     = a_bit ^ b_bit ^ c_in;
    c_out = 1'b0;
    case (op)
      OP_ADD: c_out = (a_bit & b_bit) | (a_bit & c_in) | (b_bit & c_in);
      OP_SUB: c_out = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & c_in);
      default: begin
        s     = a_bit ^ b_bit ^ seed;
        c_out = a_bit ^ b_bit ^ c_in;
      end
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial add/subtract/parity stage, one operand bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ALU_OVF_EN.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_alu_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             cin_q, cin_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_q, flag_d;
  logic             out_valid_q, out_valid_d;
`ifdef SERIAL_ALU_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic cell_s;
  logic cell_c;

  serial_alu_cell u_cell (
    .a_bit (a_q[cnt_q]),
    .b_bit (b_q[cnt_q]),
    .c_in  (carry_q),
    .seed  (cin_q),
    .op    (op_q),
    .s     (cell_s),
    .c_out (cell_c)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    cin_d       = cin_q;
    carry_d     = carry_q;
    result_d    = result_q;
    flag_d      = flag_q;
    out_valid_d = out_valid_q;
`ifdef SERIAL_ALU_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          op_d    = bus.op;
          cin_d   = bus.cin;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        result_d[cnt_q] = cell_s;
        carry_d         = cell_c;
        if (cnt_q == LAST_BIT) begin
          flag_d      = cell_c;
          out_valid_d = 1'b1;
          state_d     = DONE;
`ifdef SERIAL_ALU_OVF_EN
          // carry_q here is the carry into the MSB
          case (op_q)
            OP_ADD:  ovf_d = carry_q ^ cell_c;
            OP_SUB:  ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (cell_s != a_q[WIDTH-1]);
            default: ovf_d = 1'b0;
          endcase
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cin_q       <= 1'b0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      flag_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cin_q       <= cin_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      flag_q      <= flag_d;
      out_valid_q <= out_valid_d;
`ifdef SERIAL_ALU_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flag      = flag_q;
`ifdef SERIAL_ALU_OVF_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu using a scoreboard of expected results.
// Define SERIAL_ALU_OVF_EN to also exercise the ovf output.
module tb_serial_alu;

   localparam int WIDTH = 8;
   localparam int TIMEOUT = 4 * WIDTH;

   typedef struct {
      logic [WIDTH-1:0] result;
      logic             flag;
      logic             ovf;
   } expT;

   logic clk;
   logic rst_n;

   serial_alu_if #(.WIDTH(WIDTH)) bus ();

   serial_alu #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   expT sb[$];
   int testsRun = 0;
   int testsFailed = 0;
   expT held;

   // free-running 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference model computed from the arithmetic definitions, not the bit cell
   function automatic expT calcExpected(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b, input logic cin);
      expT e;
      logic [WIDTH:0] wide;
      e.ovf = 1'b0;
      if (op == 2'd1) begin
         wide     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
         e.result = wide[WIDTH-1:0];
         e.flag   = wide[WIDTH];
         e.ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (e.result[WIDTH-1] != a[WIDTH-1]);
      end else if (op == 2'd2) begin
         e.result = a - b - {{(WIDTH-1){1'b0}}, cin};
         e.flag   = ({1'b0, a} < ({1'b0, b} + {{WIDTH{1'b0}}, cin}));
         e.ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (e.result[WIDTH-1] != a[WIDTH-1]);
      end else begin
         e.result = a ^ b ^ {WIDTH{cin}};
         e.flag   = (^a) ^ (^b) ^ cin;
      end
      return e;
   endfunction

   // single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // drive one operand set for a single accepting edge and push its expectation
   task automatic applyStimulus(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                input logic [WIDTH-1:0] b, input logic cin);
      @(negedge clk);
      checkOutput("in_ready_before_accept", {31'b0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      sb.push_back(calcExpected(op, a, b, cin));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.op       = 2'($urandom);
      bus.a        = WIDTH'($urandom);
      bus.b        = WIDTH'($urandom);
   endtask

   // wait (bounded) for out_valid, check latency and compare against scoreboard head
   task automatic waitResult(input string tag);
      int lat;
      expT e;
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < TIMEOUT) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (bus.out_valid !== 1'b1) begin
         checkOutput({tag, "_timeout"}, {31'b0, bus.out_valid}, 32'd1);
         if (sb.size() > 0) void'(sb.pop_front());
         return;
      end
      checkOutput({tag, "_latency"}, lat, WIDTH);
      if (sb.size() == 0) begin
         checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      held = e;
      checkOutput({tag, "_result"}, {{(32-WIDTH){1'b0}}, bus.result}, {{(32-WIDTH){1'b0}}, e.result});
      checkOutput({tag, "_flag"}, {31'b0, bus.flag}, {31'b0, e.flag});
`ifdef SERIAL_ALU_OVF_EN
      checkOutput({tag, "_ovf"}, {31'b0, bus.ovf}, {31'b0, e.ovf});
`endif
   endtask

   // consume the result and confirm the block returns to IDLE
   task automatic releaseResult(input string tag);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      checkOutput({tag, "_out_valid_cleared"}, {31'b0, bus.out_valid}, 32'd0);
      checkOutput({tag, "_in_ready_back"}, {31'b0, bus.in_ready}, 32'd1);
   endtask

   task automatic runOp(input string tag, input logic [1:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic cin);
      applyStimulus(op, a, b, cin);
      waitResult(tag);
      releaseResult(tag);
   endtask

   initial begin
      int seen;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.op        = 2'd0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
      checkOutput("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
      checkOutput("reset_result", {{(32-WIDTH){1'b0}}, bus.result}, 32'd0);
      checkOutput("reset_flag", {31'b0, bus.flag}, 32'd0);
`ifdef SERIAL_ALU_OVF_EN
      checkOutput("reset_ovf", {31'b0, bus.ovf}, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      runOp("add_wrap", 2'd1, 8'hFF, 8'h01, 1'b0);
      runOp("sub_borrow", 2'd2, 8'h05, 8'h07, 1'b0);
      runOp("parity_op0", 2'd0, 8'h0F, 8'h01, 1'b1);
      runOp("parity_op3", 2'd3, 8'h0F, 8'h01, 1'b1);
      runOp("add_cin", 2'd1, 8'h7F, 8'h7F, 1'b1);
      runOp("sub_bin_equal", 2'd2, 8'h40, 8'h3F, 1'b1);
`ifdef SERIAL_ALU_OVF_EN
      runOp("ovf_add", 2'd1, 8'h7F, 8'h01, 1'b0);
      runOp("ovf_sub", 2'd2, 8'h80, 8'h01, 1'b0);
`endif

      // backpressure: result must hold and new operands must be ignored
      applyStimulus(2'd2, 8'h3C, 8'h5A, 1'b1);
      waitResult("bp");
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.op       = 2'd1;
         bus.a        = WIDTH'($urandom);
         bus.b        = WIDTH'($urandom);
         @(posedge clk);
         #1;
         checkOutput("bp_out_valid_held", {31'b0, bus.out_valid}, 32'd1);
         checkOutput("bp_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
         checkOutput("bp_result_held", {{(32-WIDTH){1'b0}}, bus.result}, {{(32-WIDTH){1'b0}}, held.result});
         checkOutput("bp_flag_held", {31'b0, bus.flag}, {31'b0, held.flag});
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b0;
      checkOutput("bp_release_in_ready", {31'b0, bus.in_ready}, 32'd1);
      checkOutput("bp_release_out_valid", {31'b0, bus.out_valid}, 32'd0);
      seen = 0;
      for (int i = 0; i < WIDTH + 3; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid === 1'b1 || bus.in_ready !== 1'b1) seen++;
      end
      checkOutput("bp_no_second_accept", seen, 0);

      // reset mid-operation abandons the transaction
      applyStimulus(2'd1, 8'hA5, 8'h5A, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      void'(sb.pop_back());
      #1;
      checkOutput("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
      checkOutput("midrst_result", {{(32-WIDTH){1'b0}}, bus.result}, 32'd0);
      checkOutput("midrst_flag", {31'b0, bus.flag}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
      runOp("post_reset_add", 2'd1, 8'h10, 8'h20, 1'b0);

      // random mix of operations
      for (int i = 0; i < 8; i++) begin
         runOp("rand", 2'($urandom), WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      end

      checkOutput("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
